// File: rtl/panel_ctrl.sv
// Front-panel controller: run/step/breakpoint sequencing of the core, panel
// memory load/look through a one-deep request, and ENTER pushes to stdin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// READY   | core held, panel accepts load/look/step/run/enter
// STEP    | core executes single instructions until the step count is reached
// RUN     | core free-running until halt, stop, breakpoint or stdin wait
// PREWAIT | one-cycle settle before waiting on stdin; resume mode is already held
// INWAIT  | core blocked on stdin, panel accepts load/look/enter
// DRAIN   | core held, waiting for it to reach an instruction boundary
module panel_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int STEP_W   = 8,
    parameter int AUTO_INC = 1,
    parameter int RESUME   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              btn_load_i,
    input  logic              btn_look_i,
    input  logic              btn_step_i,
    input  logic              btn_run_i,
    input  logic              btn_enter_i,
    input  logic              btn_stop_i,
    output logic [5:0]        btn_en_o,
    output logic              led_ready_o,
    output logic              led_inwait_o,
    output logic              led_break_o,
    input  logic [ADDR_W-1:0] sw_addr_i,
    input  logic [DATA_W-1:0] sw_data_i,
    input  logic [STEP_W-1:0] step_n_i,
    input  logic              brk_en_i,
    input  logic [ADDR_W-1:0] brk_addr_i,
    output logic [1:0]        core_exec_o,
    input  logic              core_retire_i,
    input  logic              core_idle_i,
    input  logic              core_halt_i,
    input  logic              core_inwait_i,
    input  logic [ADDR_W-1:0] core_pc_i,
    output logic              pc_wen_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              mem_val_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rdy_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stdin_val_o,
    output logic [DATA_W-1:0] stdin_data_o,
    input  logic              stdin_rdy_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] disp_o
);

    typedef enum logic [2:0] {
        S_READY, S_STEP, S_RUN, S_PREWAIT, S_INWAIT, S_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] cnt_q;
    logic              first_q;
    logic              mode_step_q;
    logic              brk_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sw_addr_q;
    logic [DATA_W-1:0] disp_q;
    logic              pend_q;
    logic              pend_wen_q;
    logic              look_rd_q;

    logic              brk_set;
    logic [STEP_W:0]   cnt_sum;
    logic [STEP_W-1:0] step_tgt;
    logic              accept;
    logic              reload;
    logic              panel_idle;

    assign step_tgt   = (step_n_i == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : step_n_i;
    assign cnt_sum    = {1'b0, cnt_q} + {{STEP_W{1'b0}}, core_retire_i};
    assign accept     = pend_q && mem_rdy_i;
    assign reload     = (sw_addr_i != sw_addr_q);
    assign panel_idle = (state_q == S_READY) || (state_q == S_INWAIT);

    always_comb begin
        state_d      = state_q;
        btn_en_o     = 6'b000000;
        core_exec_o  = 2'd0;
        led_ready_o  = 1'b0;
        led_inwait_o = 1'b0;
        brk_set      = 1'b0;
        case (state_q)
            S_READY: begin
                btn_en_o    = {1'b0, stdin_rdy_i, 4'b1111};
                led_ready_o = 1'b1;
                if (btn_run_i)       state_d = S_RUN;
                else if (btn_step_i) state_d = S_STEP;
            end
            S_RUN: begin
                core_exec_o = 2'd1;
                btn_en_o    = 6'b100000;
                if (core_halt_i)        state_d = S_DRAIN;
                else if (core_inwait_i) state_d = S_PREWAIT;
                // first_q lets a run started on the breakpoint PC move off it
                else if (brk_en_i && !first_q && core_idle_i && core_pc_i == brk_addr_i) begin
                    state_d = S_DRAIN;
                    brk_set = 1'b1;
                end
                else if (btn_stop_i)    state_d = S_DRAIN;
            end
            S_STEP: begin
                core_exec_o = 2'd2;
                btn_en_o    = 6'b100000;
                if (core_halt_i)        state_d = S_DRAIN;
                else if (core_inwait_i) state_d = S_PREWAIT;
                else if (cnt_sum >= {1'b0, step_tgt} || btn_stop_i) state_d = S_DRAIN;
            end
            S_PREWAIT: state_d = S_INWAIT;
            S_INWAIT: begin
                led_inwait_o = 1'b1;
                btn_en_o     = 6'b010011;
                if (btn_enter_i && stdin_rdy_i) begin
                    if (RESUME != 0) state_d = mode_step_q ? S_STEP : S_RUN;
                    else             state_d = S_READY;
                end
            end
            S_DRAIN: begin
                if (core_idle_i)        state_d = S_READY;
                else if (core_inwait_i) state_d = S_PREWAIT;
            end
            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_READY;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            mode_step_q <= 1'b0;
            brk_q       <= 1'b0;
            addr_q      <= sw_addr_i;
            sw_addr_q   <= sw_addr_i;
            disp_q      <= '0;
            pend_q      <= 1'b0;
            pend_wen_q  <= 1'b0;
            look_rd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= (state_d == S_RUN) && (state_q != S_RUN);
            sw_addr_q <= sw_addr_i;
            // count survives a stdin wait so a resumed step finishes its batch
            if (state_q == S_READY && state_d == S_STEP) cnt_q <= '0;
            else if (state_q == S_STEP)                  cnt_q <= cnt_sum[STEP_W-1:0];
            if (state_q == S_RUN)       mode_step_q <= 1'b0;
            else if (state_q == S_STEP) mode_step_q <= 1'b1;
            if (brk_set)                                      brk_q <= 1'b1;
            else if (state_q == S_READY && state_d != S_READY) brk_q <= 1'b0;
            if (reload)                        addr_q <= sw_addr_i;
            else if (accept && AUTO_INC != 0)  addr_q <= addr_q + ADDR_ONE;
            if (accept) begin
                pend_q <= 1'b0;
            end else if (!pend_q && panel_idle && (btn_load_i || btn_look_i)) begin
                pend_q     <= 1'b1;
                pend_wen_q <= btn_load_i;
            end
            look_rd_q <= accept && !pend_wen_q;
            if (accept && pend_wen_q) disp_q <= sw_data_i;
            else if (look_rd_q)       disp_q <= mem_rdata_i;
        end
    end

    assign led_break_o  = brk_q;
    assign pc_wen_o     = accept;
    assign pc_o         = addr_q;
    assign mem_val_o    = pend_q;
    assign mem_wen_o    = pend_wen_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = sw_data_i;
    assign stdin_val_o  = btn_enter_i && btn_en_o[4];
    assign stdin_data_o = sw_data_i;
    assign addr_o       = addr_q;
    assign disp_o       = look_rd_q ? mem_rdata_i : disp_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl: load/look, wrap, multi-step, breakpoint,
// stdin wait with resume on and off, and reset during a pending access.
module tb_panel_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        btn_load_i, btn_look_i, btn_step_i, btn_run_i, btn_enter_i, btn_stop_i;
    logic [7:0]  sw_addr_i;
    logic [15:0] sw_data_i;
    logic [7:0]  step_n_i;
    logic        brk_en_i;
    logic [7:0]  brk_addr_i;
    logic        core_retire_i, core_idle_i, core_halt_i, core_inwait_i;
    logic [7:0]  core_pc_i;
    logic        mem_rdy_i;
    logic [15:0] mem_rdata_i;
    logic        stdin_rdy_i;

    logic [5:0]  btn_en_o;
    logic        led_ready_o, led_inwait_o, led_break_o;
    logic [1:0]  core_exec_o;
    logic        pc_wen_o;
    logic [7:0]  pc_o;
    logic        mem_val_o, mem_wen_o;
    logic [7:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        stdin_val_o;
    logic [15:0] stdin_data_o;
    logic [7:0]  addr_o;
    logic [15:0] disp_o;

    logic [5:0]  r0_btn_en;
    logic        r0_ready, r0_inwait, r0_break;
    logic [1:0]  r0_exec;
    logic        r0_pc_wen;
    logic [7:0]  r0_pc;
    logic        r0_mem_val, r0_mem_wen;
    logic [7:0]  r0_mem_addr;
    logic [15:0] r0_mem_wdata;
    logic        r0_stdin_val;
    logic [15:0] r0_stdin_data;
    logic [7:0]  r0_addr;
    logic [15:0] r0_disp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    panel_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .btn_load_i(btn_load_i), .btn_look_i(btn_look_i), .btn_step_i(btn_step_i),
        .btn_run_i(btn_run_i), .btn_enter_i(btn_enter_i), .btn_stop_i(btn_stop_i),
        .btn_en_o(btn_en_o), .led_ready_o(led_ready_o), .led_inwait_o(led_inwait_o),
        .led_break_o(led_break_o), .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i),
        .step_n_i(step_n_i), .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i),
        .core_exec_o(core_exec_o), .core_retire_i(core_retire_i), .core_idle_i(core_idle_i),
        .core_halt_i(core_halt_i), .core_inwait_i(core_inwait_i), .core_pc_i(core_pc_i),
        .pc_wen_o(pc_wen_o), .pc_o(pc_o), .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdy_i(mem_rdy_i),
        .mem_rdata_i(mem_rdata_i), .stdin_val_o(stdin_val_o), .stdin_data_o(stdin_data_o),
        .stdin_rdy_i(stdin_rdy_i), .addr_o(addr_o), .disp_o(disp_o)
    );

    panel_ctrl #(.RESUME(0)) dut_nores (
        .clk_i(clk_i), .rst_i(rst_i),
        .btn_load_i(btn_load_i), .btn_look_i(btn_look_i), .btn_step_i(btn_step_i),
        .btn_run_i(btn_run_i), .btn_enter_i(btn_enter_i), .btn_stop_i(btn_stop_i),
        .btn_en_o(r0_btn_en), .led_ready_o(r0_ready), .led_inwait_o(r0_inwait),
        .led_break_o(r0_break), .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i),
        .step_n_i(step_n_i), .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i),
        .core_exec_o(r0_exec), .core_retire_i(core_retire_i), .core_idle_i(core_idle_i),
        .core_halt_i(core_halt_i), .core_inwait_i(core_inwait_i), .core_pc_i(core_pc_i),
        .pc_wen_o(r0_pc_wen), .pc_o(r0_pc), .mem_val_o(r0_mem_val), .mem_wen_o(r0_mem_wen),
        .mem_addr_o(r0_mem_addr), .mem_wdata_o(r0_mem_wdata), .mem_rdy_i(mem_rdy_i),
        .mem_rdata_i(mem_rdata_i), .stdin_val_o(r0_stdin_val), .stdin_data_o(r0_stdin_data),
        .stdin_rdy_i(stdin_rdy_i), .addr_o(r0_addr), .disp_o(r0_disp)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        btn_load_i = 0; btn_look_i = 0; btn_step_i = 0; btn_run_i = 0; btn_enter_i = 0; btn_stop_i = 0;
        sw_addr_i = 8'h10; sw_data_i = 16'h0000; step_n_i = 8'd1;
        brk_en_i = 0; brk_addr_i = 8'h00;
        core_retire_i = 0; core_idle_i = 0; core_halt_i = 0; core_inwait_i = 0; core_pc_i = 8'h00;
        mem_rdy_i = 0; mem_rdata_i = 16'h0000; stdin_rdy_i = 0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_ready", led_ready_o, 1);
        chk("rst_exec", core_exec_o, 0);
        chk("rst_disp", disp_o, 0);
        chk("rst_memval", mem_val_o, 0);
        chk("rst_addr", addr_o, 8'h10);
        chk("rst_btn_en", btn_en_o, 6'b001111);
        chk("rst_break", led_break_o, 0);

        // load 0xBEEF at 0x10, ready two cycles after the request
        sw_data_i = 16'hBEEF; btn_load_i = 1;
        tick();
        btn_load_i = 0;
        chk("ld_val", mem_val_o, 1);
        chk("ld_wen", mem_wen_o, 1);
        chk("ld_addr", mem_addr_o, 8'h10);
        chk("ld_wdata", mem_wdata_o, 16'hBEEF);
        chk("ld_pcwen_early", pc_wen_o, 0);
        btn_look_i = 1;
        tick();
        btn_look_i = 0; mem_rdy_i = 1;
        #1;
        chk("ld_pcwen", pc_wen_o, 1);
        chk("ld_pc", pc_o, 8'h10);
        chk("ld_val_acc", mem_val_o, 1);
        tick();
        mem_rdy_i = 0;
        #1;
        chk("ld_look_ignored", mem_val_o, 0);
        chk("ld_disp", disp_o, 16'hBEEF);
        chk("ld_addr_inc", addr_o, 8'h11);
        chk("ld_pcwen_once", pc_wen_o, 0);

        // look at 0xFF with wrap to 0x00
        sw_addr_i = 8'hFF;
        tick();
        chk("lk_reload", addr_o, 8'hFF);
        btn_look_i = 1;
        tick();
        btn_look_i = 0; mem_rdy_i = 1;
        #1;
        chk("lk_val", mem_val_o, 1);
        chk("lk_wen", mem_wen_o, 0);
        chk("lk_addr", mem_addr_o, 8'hFF);
        chk("lk_pcwen", pc_wen_o, 1);
        chk("lk_pc", pc_o, 8'hFF);
        tick();
        mem_rdy_i = 0; mem_rdata_i = 16'h1234;
        #1;
        chk("lk_disp", disp_o, 16'h1234);
        chk("lk_wrap", addr_o, 8'h00);
        tick();
        mem_rdata_i = 16'h0000;
        #1;
        chk("lk_disp_hold", disp_o, 16'h1234);

        // step of three
        step_n_i = 8'd3; btn_step_i = 1;
        tick();
        btn_step_i = 0;
        chk("st_exec0", core_exec_o, 2);
        chk("st_btn_en", btn_en_o, 6'b100000);
        chk("st_ready", led_ready_o, 0);
        core_retire_i = 1;
        tick();
        core_retire_i = 0;
        chk("st_exec1", core_exec_o, 2);
        tick();
        core_retire_i = 1;
        tick();
        core_retire_i = 0;
        chk("st_exec2", core_exec_o, 2);
        core_retire_i = 1;
        #1;
        chk("st_exec3", core_exec_o, 2);
        tick();
        core_retire_i = 0;
        chk("st_drain_exec", core_exec_o, 0);
        chk("st_drain_en", btn_en_o, 0);
        chk("st_drain_ready", led_ready_o, 0);
        core_idle_i = 1;
        tick();
        core_idle_i = 0;
        chk("st_ready_back", led_ready_o, 1);

        // step count of zero behaves as one
        step_n_i = 8'd0; btn_step_i = 1;
        tick();
        btn_step_i = 0;
        chk("s0_exec", core_exec_o, 2);
        core_retire_i = 1;
        tick();
        core_retire_i = 0;
        chk("s0_drain", core_exec_o, 0);
        core_idle_i = 1;
        tick();
        core_idle_i = 0;
        chk("s0_ready", led_ready_o, 1);

        // breakpoint at 0x20, run started at 0x20
        brk_en_i = 1; brk_addr_i = 8'h20; core_pc_i = 8'h20; core_idle_i = 1; btn_run_i = 1;
        tick();
        btn_run_i = 0;
        chk("bp_run", core_exec_o, 1);
        tick();
        chk("bp_no_immediate", core_exec_o, 1);
        chk("bp_led_off", led_break_o, 0);
        core_pc_i = 8'h21;
        tick();
        chk("bp_other_pc", core_exec_o, 1);
        core_pc_i = 8'h20;
        tick();
        chk("bp_drain", core_exec_o, 0);
        chk("bp_led", led_break_o, 1);
        tick();
        chk("bp_ready", led_ready_o, 1);
        chk("bp_led_hold", led_break_o, 1);
        core_idle_i = 0; brk_en_i = 0;

        // stdin wait and resume
        btn_run_i = 1;
        tick();
        btn_run_i = 0;
        chk("iw_run", core_exec_o, 1);
        chk("iw_break_clr", led_break_o, 0);
        core_inwait_i = 1;
        tick();
        chk("iw_pre_exec", core_exec_o, 0);
        chk("iw_pre_en", btn_en_o, 0);
        chk("iw_pre_led", led_inwait_o, 0);
        tick();
        core_inwait_i = 0;
        chk("iw_led", led_inwait_o, 1);
        chk("iw_en", btn_en_o, 6'b010011);
        sw_data_i = 16'h0005; btn_enter_i = 1; stdin_rdy_i = 0;
        #1;
        chk("iw_val_norm", stdin_val_o, 1);
        tick();
        chk("iw_dropped", led_inwait_o, 1);
        stdin_rdy_i = 1;
        #1;
        chk("iw_push_val", stdin_val_o, 1);
        chk("iw_push_data", stdin_data_o, 16'h0005);
        tick();
        btn_enter_i = 0; stdin_rdy_i = 0;
        chk("iw_resume_run", core_exec_o, 1);
        chk("iw_nores_ready", r0_ready, 1);
        chk("iw_nores_exec", r0_exec, 0);
        btn_stop_i = 1;
        tick();
        btn_stop_i = 0;
        chk("stop_drain", core_exec_o, 0);
        core_idle_i = 1;
        tick();
        core_idle_i = 0;
        chk("stop_ready", led_ready_o, 1);

        // reset during a pending look
        sw_addr_i = 8'h40;
        tick();
        chk("rl_addr", addr_o, 8'h40);
        btn_look_i = 1;
        tick();
        btn_look_i = 0;
        chk("rl_pending", mem_val_o, 1);
        rst_i = 1;
        tick();
        rst_i = 0;
        #1;
        chk("rl_memval", mem_val_o, 0);
        chk("rl_disp", disp_o, 0);
        chk("rl_ready", led_ready_o, 1);
        chk("rl_addr_rst", addr_o, 8'h40);
        chk("rl_exec", core_exec_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
